// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge control stage.
// Sequences APB SETUP/ACCESS phases and stalls AHB via hreadyout.
module apb_fsm_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSEL   = 3
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [ADDR_W-1:0] haddr1,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [NSEL-1:0]   temp_selx,
  input  logic              pready,
  output logic              hreadyout,
  output logic [NSEL-1:0]   pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WWAIT  = 2'd1,
    SETUP  = 2'd2,
    ACCESS = 2'd3
  } state_e;

  state_e            state_q;
  logic [NSEL-1:0]   sel_q;
  logic [NSEL-1:0]   pselx_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              ready;
  logic              accept;

  // AHB is released when idle or when the APB access completes.
  always_comb begin
    ready  = (state_q == IDLE) |
             ((state_q == ACCESS) & pready);
    accept = valid & ready;
  end

  // Protocol sequencer with registered APB outputs.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      pselx_q   <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE, ACCESS: begin
          // A stalled ACCESS (pready=0) holds everything.
          if (ready) begin
            if (accept && hwrite) begin
              // Write data arrives next cycle; park the select.
              state_q   <= WWAIT;
              sel_q     <= temp_selx;
              pselx_q   <= '0;
              penable_q <= 1'b0;
            end else if (accept) begin
              state_q   <= SETUP;
              pselx_q   <= temp_selx;
              paddr_q   <= haddr;
              pwrite_q  <= 1'b0;
              penable_q <= 1'b0;
            end else begin
              state_q   <= IDLE;
              pselx_q   <= '0;
              penable_q <= 1'b0;
            end
          end
        end
        WWAIT: begin
          state_q   <= SETUP;
          pselx_q   <= sel_q;
          paddr_q   <= haddr1;
          pwdata_q  <= hwdata;
          pwrite_q  <= 1'b1;
          penable_q <= 1'b0;
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hreadyout = ready;
  assign pselx     = pselx_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Bench for apb_fsm_controller: directed protocol steps,
// then random traffic against a per-transfer timeline model.
module tb_apb_fsm_controller;

  logic        hclk;
  logic        hreset;
  logic        valid;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] haddr1;
  logic [31:0] hwdata;
  logic [2:0]  temp_selx;
  logic        pready;
  logic        hreadyout;
  logic [2:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;

  int n_asserts = 0;
  int n_fail    = 0;

  apb_fsm_controller #(
    .ADDR_W(32), .DATA_W(32), .NSEL(3)
  ) dut (
    .hclk(hclk), .hreset(hreset), .valid(valid),
    .hwrite(hwrite), .haddr(haddr), .haddr1(haddr1),
    .hwdata(hwdata), .temp_selx(temp_selx),
    .pready(pready), .hreadyout(hreadyout),
    .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Slave-interface address pipeline register.
  always @(posedge hclk) haddr1 <= haddr;

  // One cycle of the transfer timeline seen on the APB side.
  localparam int K_WW = 1;
  localparam int K_SU = 2;
  localparam int K_AC = 3;
  typedef struct {
    int          kind;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic        rdy;
  } step_t;
  step_t sched[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_sel,
                         input logic e_en, input logic e_wr,
                         input logic [31:0] e_addr,
                         input logic [31:0] e_data,
                         input logic e_rdy);
    chk({tag, ".pselx"},     {29'd0, pselx},     {29'd0, e_sel});
    chk({tag, ".penable"},   {31'd0, penable},   {31'd0, e_en});
    chk({tag, ".pwrite"},    {31'd0, pwrite},    {31'd0, e_wr});
    chk({tag, ".paddr"},     paddr,              e_addr);
    chk({tag, ".pwdata"},    pwdata,             e_data);
    chk({tag, ".hreadyout"}, {31'd0, hreadyout}, {31'd0, e_rdy});
  endtask

  task automatic drive(input logic v, input logic w,
                       input logic [31:0] a, input logic [2:0] s,
                       input logic [31:0] d, input logic r);
    @(negedge hclk);
    valid     = v;
    hwrite    = w;
    haddr     = a;
    temp_selx = s;
    hwdata    = d;
    pready    = r;
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge hclk);
    hreset = 1'b1;
    valid  = 1'b0;
    @(negedge hclk);
    hreset = 1'b0;
  endtask

  initial begin
    step_t       e;
    step_t       n;
    bit          have;
    logic        rv, rw, rp;
    logic [31:0] ra, rd;
    logic [2:0]  rs;
    logic [2:0]  x_sel;
    logic        x_en, x_rdy;
    logic [31:0] m_addr, m_data;
    logic        m_wr;
    int          w;

    hreset    = 1'b1;
    valid     = 1'b0;
    hwrite    = 1'b0;
    haddr     = '0;
    hwdata    = '0;
    temp_selx = 3'b001;
    pready    = 1'b0;
    repeat (2) @(negedge hclk);
    #1;
    chk_all("reset", 3'b000, 0, 0, 32'h0, 32'h0, 1);
    @(negedge hclk);
    hreset = 1'b0;

    // Read with zero wait states.
    drive(1, 0, 32'h8000_0010, 3'b001, 32'h0, 1);
    chk_all("rd.A", 3'b000, 0, 0, 32'h0, 32'h0, 1);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 1);
    chk_all("rd.setup", 3'b001, 0, 0, 32'h8000_0010, 32'h0, 0);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 1);
    chk_all("rd.access", 3'b001, 1, 0, 32'h8000_0010, 32'h0, 1);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 1);
    chk_all("rd.idle", 3'b000, 0, 0, 32'h8000_0010, 32'h0, 1);

    // Write: data phase one cycle after the address phase.
    drive(1, 1, 32'h8400_0020, 3'b010, 32'h0, 1);
    drive(0, 0, 32'h0, 3'b001, 32'hDEAD_BEEF, 1);
    chk_all("wr.wwait", 3'b000, 0, 0, 32'h8000_0010, 32'h0, 0);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 1);
    chk_all("wr.setup", 3'b010, 0, 1, 32'h8400_0020,
            32'hDEAD_BEEF, 0);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 1);
    chk_all("wr.access", 3'b010, 1, 1, 32'h8400_0020,
            32'hDEAD_BEEF, 1);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 1);
    chk_all("wr.idle", 3'b000, 0, 1, 32'h8400_0020,
            32'hDEAD_BEEF, 1);

    // Read with two wait states.
    drive(1, 0, 32'h8800_0004, 3'b100, 32'h0, 0);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 0);
    chk_all("ws.setup", 3'b100, 0, 0, 32'h8800_0004,
            32'hDEAD_BEEF, 0);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 0);
    chk_all("ws.acc1", 3'b100, 1, 0, 32'h8800_0004,
            32'hDEAD_BEEF, 0);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 0);
    chk_all("ws.acc2", 3'b100, 1, 0, 32'h8800_0004,
            32'hDEAD_BEEF, 0);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 1);
    chk_all("ws.acc3", 3'b100, 1, 0, 32'h8800_0004,
            32'hDEAD_BEEF, 1);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 1);
    chk_all("ws.idle", 3'b000, 0, 0, 32'h8800_0004,
            32'hDEAD_BEEF, 1);

    // Back-to-back write then read, no idle cycle between.
    drive(1, 1, 32'h8000_0000, 3'b001, 32'h0, 1);
    drive(0, 0, 32'h0, 3'b001, 32'h1234_5678, 1);
    chk_all("bb.wwait", 3'b000, 0, 0, 32'h8800_0004,
            32'hDEAD_BEEF, 0);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 1);
    chk_all("bb.wsetup", 3'b001, 0, 1, 32'h8000_0000,
            32'h1234_5678, 0);
    drive(1, 0, 32'h8800_0008, 3'b100, 32'h0, 1);
    chk_all("bb.waccess", 3'b001, 1, 1, 32'h8000_0000,
            32'h1234_5678, 1);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 1);
    chk_all("bb.rsetup", 3'b100, 0, 0, 32'h8800_0008,
            32'h1234_5678, 0);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 1);
    chk_all("bb.raccess", 3'b100, 1, 0, 32'h8800_0008,
            32'h1234_5678, 1);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 1);
    chk_all("bb.idle", 3'b000, 0, 0, 32'h8800_0008,
            32'h1234_5678, 1);

    // Asynchronous reset in the middle of ACCESS.
    drive(1, 0, 32'h8000_0100, 3'b001, 32'h0, 0);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 0);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 0);
    chk_all("rst.access", 3'b001, 1, 0, 32'h8000_0100,
            32'h1234_5678, 0);
    #2;
    hreset = 1'b1;
    valid  = 1'b0;
    #1;
    chk_all("rst.async", 3'b000, 0, 0, 32'h0, 32'h0, 1);
    @(negedge hclk);
    hreset = 1'b0;
    drive(1, 0, 32'h8000_0200, 3'b001, 32'h0, 1);
    chk_all("rst.A", 3'b000, 0, 0, 32'h0, 32'h0, 1);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 1);
    chk_all("rst.setup", 3'b001, 0, 0, 32'h8000_0200, 32'h0, 0);
    drive(0, 0, 32'h0, 3'b001, 32'h0, 1);
    chk_all("rst.access2", 3'b001, 1, 0, 32'h8000_0200, 32'h0, 1);

    // No traffic.
    for (int i = 0; i < 10; i++) begin
      drive(0, $urandom_range(0, 1), $urandom, 3'b010, $urandom,
            $urandom_range(0, 1));
      chk_all("idle", 3'b000, 0, 0, 32'h8000_0200, 32'h0, 1);
    end

    // Random traffic against the transfer timeline model.
    reset_pulse();
    sched.delete();
    m_addr = '0;
    m_data = '0;
    m_wr   = 1'b0;
    for (int c = 0; c < 600; c++) begin
      have = (sched.size() > 0);
      if (have) e = sched.pop_front();
      rv = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      ra = $urandom;
      rd = $urandom;
      rs = 3'(1 << $urandom_range(0, 2));
      rp = 1'($urandom_range(0, 1));
      if (have && e.kind == K_WW) rd = e.data;
      if (have && e.kind == K_AC) rp = e.rdy;
      drive(rv, rw, ra, rs, rd, rp);
      x_sel = 3'b000;
      x_en  = 1'b0;
      x_rdy = 1'b1;
      if (have) begin
        x_rdy = 1'b0;
        if (e.kind == K_SU) begin
          m_addr = e.addr;
          m_wr   = e.wr;
          if (e.wr) m_data = e.data;
          x_sel = e.sel;
        end else if (e.kind == K_AC) begin
          x_sel = e.sel;
          x_en  = 1'b1;
          x_rdy = e.rdy;
        end
      end
      chk_all("rand", x_sel, x_en, m_wr, m_addr, m_data, x_rdy);
      if (rv && x_rdy) begin
        n.sel  = rs;
        n.addr = ra;
        n.wr   = rw;
        n.data = $urandom;
        n.rdy  = 1'b0;
        if (rw) begin
          n.kind = K_WW;
          sched.push_back(n);
        end
        n.kind = K_SU;
        sched.push_back(n);
        w = $urandom_range(0, 3);
        n.kind = K_AC;
        for (int k = 0; k < w; k++) sched.push_back(n);
        n.rdy = 1'b1;
        sched.push_back(n);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
